// File: rtl/mem_rmw_responder.sv
// mem_rmw_responder: word RAM responder for the multicycle MIPS datapath; sub-word stores are read-modify-write
module mem_rmw_responder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ack,
  output logic        Busy,
  output logic        Misaligned
);
  typedef enum logic [1:0] {IDLE, FETCH, MODIFY, ACK} state_t;
  state_t state, next;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH+1:0] addr_q;
  logic wr_q, byte_q, half_q, mis_q;
  logic [31:0] wdata_q, word_q, mask, lane, merged;
  logic [4:0] sh;
  logic in_byte, in_half, in_mis, unused_addr;
  assign unused_addr = ^Address[31:ADDR_WIDTH+2];
  assign in_byte = Size == 2'b01;
  assign in_half = Size == 2'b10;
  assign in_mis = in_half ? Address[0] : !in_byte && Address[1:0] != 2'b00;
  // big-endian lanes: offset 0 is the most significant byte/halfword
  assign sh = byte_q ? {~addr_q[1:0], 3'b000} : half_q ? {~addr_q[1], 4'b0000} : 5'd0;
  assign mask = byte_q ? 32'hFF << sh : half_q ? 32'hFFFF << sh : 32'hFFFF_FFFF;
  assign lane = (word_q & mask) >> sh;
  assign merged = ((wdata_q << sh) & mask) | (word_q & ~mask);
  always_comb begin
    next = IDLE;
    if (state == IDLE && Req) next = in_mis ? ACK : FETCH;
    else if (state == FETCH) next = MODIFY;
    else if (state == MODIFY) next = ACK;
    Ack = state == ACK;
    Busy = state != IDLE;
    Misaligned = Ack && mis_q;
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      ReadData <= '0;
      mis_q <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && Req) mis_q <= in_mis;
      if (state == IDLE && Req && in_mis) ReadData <= '0;
      else if (state == MODIFY && !wr_q) ReadData <= lane;
    end
  // state is cleared asynchronously, so an abandoned request never reaches the write below
  always_ff @(posedge Clk) begin
    if (state == IDLE && Req) begin
      addr_q <= Address[ADDR_WIDTH+1:0];
      wr_q <= Wr;
      byte_q <= in_byte;
      half_q <= in_half;
      wdata_q <= WriteData;
    end
    if (state == FETCH) word_q <= mem[addr_q[ADDR_WIDTH+1:2]];
    if (state == MODIFY && wr_q) mem[addr_q[ADDR_WIDTH+1:2]] <= merged;
  end
endmodule

// File: tb/tb_mem_rmw_responder.sv
// tb_mem_rmw_responder: directed and randomized requests checked against a byte-addressed memory model
module tb_mem_rmw_responder;
  logic Clk = 1'b0, Reset = 1'b1, Req = 1'b0, Wr = 1'b0;
  logic [1:0] Size = 2'b00;
  logic [31:0] Address = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic Ack, Busy, Misaligned;
  int checks = 0, errors = 0;
  logic [7:0] mb [1024];
  logic [31:0] last_rd = '0;

  mem_rmw_responder dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Size(Size), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData), .Ack(Ack), .Busy(Busy), .Misaligned(Misaligned)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_mis(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b10) ? a[0] : (s != 2'b01) && (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] s, input logic [31:0] a);
    int i = int'(a[9:0]);
    case (s)
      2'b01: return {24'b0, mb[i]};
      2'b10: return {16'b0, mb[i], mb[i+1]};
      default: return {mb[i], mb[i+1], mb[i+2], mb[i+3]};
    endcase
  endfunction

  task automatic m_write(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    int i = int'(a[9:0]);
    case (s)
      2'b01: mb[i] = d[7:0];
      2'b10: begin mb[i] = d[15:8]; mb[i+1] = d[7:0]; end
      default: begin mb[i] = d[31:24]; mb[i+1] = d[23:16]; mb[i+2] = d[15:8]; mb[i+3] = d[7:0]; end
    endcase
  endtask

  task automatic run(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d, input string tag);
    int lat;
    logic bad;
    bad = m_mis(s, a);
    @(negedge Clk);
    chk({tag, "/idle_busy"}, {31'b0, Busy}, 32'd0);
    chk({tag, "/idle_ack"}, {31'b0, Ack}, 32'd0);
    Req = 1'b1; Wr = w; Size = s; Address = a; WriteData = d;
    @(posedge Clk);
    #1;
    Req = 1'b0; Wr = 1'($urandom); Size = 2'($urandom); Address = $urandom; WriteData = $urandom;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (!Ack && lat < 8);
    if (bad) last_rd = '0;
    else if (!w) last_rd = m_read(s, a);
    else m_write(s, a, d);
    chk({tag, "/lat"}, 32'(lat), bad ? 32'd1 : 32'd3);
    chk({tag, "/busy"}, {31'b0, Busy}, 32'd1);
    chk({tag, "/mis"}, {31'b0, Misaligned}, {31'b0, bad});
    chk({tag, "/rd"}, ReadData, last_rd);
  endtask

  initial begin
    logic [31:0] a;
    #1 Reset = 1'b0;
    #11;
    chk("rst_ack", {31'b0, Ack}, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_mis", {31'b0, Misaligned}, 32'd0);
    chk("rst_rd", ReadData, 32'd0);
    @(negedge Clk) Reset = 1'b1;
    for (int k = 0; k < 64; k += 4) run(1'b1, 2'b00, 32'(k), $urandom, "init");
    run(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, "sw10");
    run(1'b0, 2'b00, 32'h10, 32'h0, "lw10");
    chk("lw10_const", ReadData, 32'hDEADBEEF);
    run(1'b1, 2'b01, 32'h12, 32'hFFFFFF55, "sb12");
    run(1'b0, 2'b00, 32'h10, 32'h0, "lw10_b");
    chk("lw10_b_const", ReadData, 32'hDEAD55EF);
    run(1'b0, 2'b01, 32'h11, 32'h0, "lb11");
    chk("lb11_const", ReadData, 32'h000000AD);
    run(1'b1, 2'b10, 32'h10, 32'hABCD1234, "sh10");
    run(1'b0, 2'b10, 32'h10, 32'h0, "lh10");
    chk("lh10_const", ReadData, 32'h00001234);
    run(1'b0, 2'b00, 32'h10, 32'h0, "lw10_c");
    chk("lw10_c_const", ReadData, 32'h123455EF);
    run(1'b0, 2'b00, 32'h13, 32'h0, "lw13_mis");
    run(1'b1, 2'b10, 32'h11, 32'hFFFFFFFF, "sh11_mis");
    run(1'b0, 2'b00, 32'h10, 32'h0, "lw10_d");
    chk("lw10_d_const", ReadData, 32'h123455EF);
    // Req held high: one request every 4 cycles alternating between word 0 and word 4
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b0; Size = 2'b00; Address = 32'h0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge Clk);
      chk("b2b_ack", {31'b0, Ack}, {31'b0, c % 4 == 3});
      chk("b2b_busy", {31'b0, Busy}, {31'b0, c % 4 != 0});
      if (c % 4 == 3) chk("b2b_rd", ReadData, m_read(2'b00, ((c / 4) % 2 == 1) ? 32'h4 : 32'h0));
      if (c % 4 == 0) Address = Address ^ 32'h4;
    end
    Req = 1'b0;
    last_rd = m_read(2'b00, 32'h4);
    for (int k = 0; k < 80; k++) begin
      a = $urandom;
      a[9:6] = 4'h0;
      run(1'($urandom), 2'($urandom), a, $urandom, "rnd");
    end
    run(1'b0, 2'b00, 32'h20, 32'h0, "pre_rst");
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b1; Size = 2'b00; Address = 32'h20; WriteData = 32'hCAFEF00D;
    @(posedge Clk);
    #1 Req = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("rst_fetch_ack", {31'b0, Ack}, 32'd0);
    chk("rst_fetch_busy", {31'b0, Busy}, 32'd0);
    chk("rst_fetch_rd", ReadData, 32'd0);
    @(negedge Clk);
    @(negedge Clk) Reset = 1'b1;
    last_rd = '0;
    run(1'b0, 2'b00, 32'h20, 32'h0, "post_rst_fetch");
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b1; Size = 2'b01; Address = 32'h25; WriteData = 32'h0000005A;
    @(posedge Clk);
    #1 Req = 1'b0;
    @(posedge Clk);
    #3 Reset = 1'b0;
    #1;
    chk("rst_modify_busy", {31'b0, Busy}, 32'd0);
    @(negedge Clk);
    @(negedge Clk) Reset = 1'b1;
    last_rd = '0;
    run(1'b0, 2'b00, 32'h24, 32'h0, "post_rst_modify");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
